// File: rtl/nios_mulx_sequencer.sv
// nios_mulx_sequencer: steps four 16x16 partial products through the external
// fast multiply cell and accumulates them into a 64-bit product. Signed forms
// get a high-word fix-up before the result is published.
// Optional build macro: NIOS_MULX_EARLY_OUT_EN issues only the low partial
// product when both operands fit in 16 bits and the op is unsigned.
module nios_mulx_sequencer #(
  parameter int CELL_LATENCY = 1,
  parameter int ACC_W        = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        ready,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  input  logic [31:0] cell_result,
  output logic        done,
  output logic [31:0] result_hi,
  output logic [31:0] result_lo
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_CORRECT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         k_q, k_d;
  logic [1:0]         dcnt_q, dcnt_d;
  logic [31:0]        a_q, b_q;
  logic [1:0]         op_q;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [31:0]        res_hi_q, res_lo_q;
  logic [31:0]        corr_hi;
  logic               last_issue;
  logic [5:0]         shamt;

  // Valid tag plus issue index for every product still inside the cell.
  logic [CELL_LATENCY-1:0]      tag_vld_q;
  logic [CELL_LATENCY-1:0][1:0] tag_k_q;

  wire accept = (state_q == S_IDLE) && start;

`ifdef NIOS_MULX_EARLY_OUT_EN
  // Small unsigned operands need only the low x low product.
  wire early = (a_q[31:16] == 16'h0) && (b_q[31:16] == 16'h0) && (op_q == 2'b00);
  assign last_issue = early ? (k_q == 2'd0) : (k_q == 2'd3);
`else
  assign last_issue = (k_q == 2'd3);
`endif

  // High-word correction turning the unsigned product into the signed form.
  always_comb begin
    corr_hi = acc_q[ACC_W-1:ACC_W-32];
    if (op_q[0] && a_q[31])          corr_hi = corr_hi - b_q;
    if ((op_q == 2'b11) && b_q[31])  corr_hi = corr_hi - a_q;
  end

  // Shift that places the partial product now leaving the cell.
  always_comb begin
    case (tag_k_q[CELL_LATENCY-1])
      2'd0:    shamt = 6'd0;
      2'd3:    shamt = 6'd32;
      default: shamt = 6'd16;
    endcase
  end

  // Next state, accumulator update and cell operand drive.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    dcnt_d    = dcnt_q;
    acc_d     = acc_q;
    cell_src1 = 32'h0;
    cell_src2 = 32'h0;
    if (tag_vld_q[CELL_LATENCY-1])
      acc_d = acc_q + ({{(ACC_W-32){1'b0}}, cell_result} << shamt);
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_ISSUE;
        k_d     = 2'd0;
        acc_d   = '0;
      end
      S_ISSUE: begin
        cell_src1 = {16'h0, k_q[0] ? a_q[31:16] : a_q[15:0]};
        cell_src2 = {16'h0, k_q[1] ? b_q[31:16] : b_q[15:0]};
        if (last_issue) begin
          state_d = S_DRAIN;
          dcnt_d  = 2'd0;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      S_DRAIN: begin
        if (dcnt_q == 2'(CELL_LATENCY - 1)) state_d = S_CORRECT;
        else                                dcnt_d  = dcnt_q + 2'd1;
      end
      S_CORRECT: begin
        acc_d[ACC_W-1:ACC_W-32] = corr_hi;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, operands, accumulator, cell tag pipe and published result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      k_q       <= 2'd0;
      dcnt_q    <= 2'd0;
      a_q       <= 32'h0;
      b_q       <= 32'h0;
      op_q      <= 2'b00;
      acc_q     <= '0;
      tag_vld_q <= '0;
      tag_k_q   <= '0;
      res_hi_q  <= 32'h0;
      res_lo_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      dcnt_q  <= dcnt_d;
      acc_q   <= acc_d;
      if (accept) begin
        a_q  <= src1;
        b_q  <= src2;
        op_q <= (op == 2'b10) ? 2'b00 : op;   // reserved code behaves as unsigned
      end
      tag_vld_q[0] <= (state_q == S_ISSUE);
      tag_k_q[0]   <= k_q;
      for (int i = 1; i < CELL_LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_k_q[i]   <= tag_k_q[i-1];
      end
      if (state_q == S_CORRECT) begin
        res_hi_q <= corr_hi;
        res_lo_q <= acc_q[31:0];
      end
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign result_hi = res_hi_q;
  assign result_lo = res_lo_q;

endmodule

// File: tb/tb_nios_mulx_sequencer.sv
// Bench for nios_mulx_sequencer: models the multiply cell, checks products
// against plain 64-bit arithmetic, and checks latency, ready/done handshake,
// back-to-back issue and mid-operation reset.
module tb_nios_mulx_sequencer;
  localparam int L = 1;

  logic        clk = 1'b0;
  logic        reset, start, ready, done;
  logic [1:0]  op;
  logic [31:0] src1, src2, cell_src1, cell_src2, cell_result, result_hi, result_lo;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  nios_mulx_sequencer #(.CELL_LATENCY(L), .ACC_W(64)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src1(src1), .src2(src2),
    .ready(ready), .cell_src1(cell_src1), .cell_src2(cell_src2),
    .cell_result(cell_result), .done(done),
    .result_hi(result_hi), .result_lo(result_lo));

  // Registered multiply cell with L cycles of latency.
  logic [31:0] cpipe [L];
  always @(posedge clk) begin
    cpipe[0] <= cell_src1 * cell_src2;
    for (int i = 1; i < L; i++) cpipe[i] <= cpipe[i-1];
  end
  assign cell_result = cpipe[L-1];

  function automatic logic [63:0] ref_prod(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = o[0]        ? {{32{a[31]}}, a} : {32'h0, a};
    sb = (o == 2'b11) ? {{32{b[31]}}, b} : {32'h0, b};
    return sa * sb;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called just after a negedge in IDLE; returns just after a negedge in IDLE.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit noise);
    logic [63:0] p;
    int lat, dn;
    bit rdy_bad;
    p   = ref_prod(o, a, b);
    lat = L + 6;
`ifdef NIOS_MULX_EARLY_OUT_EN
    if (a[31:16] == 16'h0 && b[31:16] == 16'h0 && o[0] == 1'b0) lat = L + 3;
`endif
    chk("ready_pre", ready, 1);
    start = 1; op = o; src1 = a; src2 = b;
    @(posedge clk);
    dn = 0; rdy_bad = 0;
    for (int n = 1; n <= 40 && dn == 0; n++) begin
      @(negedge clk);
      if (ready !== 1'b0) rdy_bad = 1;
      if (done === 1'b1) dn = n;
      start = (noise && n < lat - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin op = 2'($urandom); src1 = $urandom; src2 = $urandom; end
    end
    start = 0;
    chk("latency", dn, lat);
    chk("ready_busy", rdy_bad, 0);
    chk("hi", result_hi, p[63:32]);
    chk("lo", result_lo, p[31:0]);
    chk("cell_idle", {cell_src1, cell_src2}, 64'h0);
    @(negedge clk);
    chk("ready_post", ready, 1);
    chk("done_pulse", done, 0);
    chk("hold", {result_hi, result_lo}, p);
  endtask

  initial begin
    int d1, d2, k;
    bit rb, dseen;
    logic [31:0] ra, rbv;
    reset = 1; start = 0; op = 0; src1 = 0; src2 = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_res", {result_hi, result_lo}, 64'h0);
    chk("rst_cell", {cell_src1, cell_src2}, 64'h0);

    // Directed products
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    chk("plan_uu", {result_hi, result_lo}, 64'hFFFFFFFE_00000001);
    run_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    chk("plan_ss", {result_hi, result_lo}, 64'h00000000_00000001);
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    chk("plan_su", {result_hi, result_lo}, 64'hFFFFFFFF_00000001);
    run_op(2'b11, 32'h80000000, 32'h00000002, 0);
    chk("plan_ss_min", {result_hi, result_lo}, 64'hFFFFFFFF_00000000);
    run_op(2'b00, 32'h80000000, 32'h00000002, 0);
    run_op(2'b10, 32'hFFFFFFFF, 32'h00000003, 0);
    run_op(2'b00, 32'h0000FFFF, 32'h0000FFFF, 0);
    chk("plan_small", {result_hi, result_lo}, 64'h00000000_FFFE0001);
    run_op(2'b11, 32'h0, 32'h0, 0);

    // Back-to-back with start held high
    start = 1; op = 2'b00; src1 = 32'h00010000; src2 = 32'h00010000;
    @(posedge clk);
    d1 = 0; d2 = 0; rb = 0;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin if (d1 == 0) d1 = n; else d2 = n; end
      if (n != 8 && ready !== 1'b0) rb = 1;
      if (n == 8 && ready !== 1'b1) rb = 1;
    end
    @(negedge clk);
    start = 0;
    chk("b2b_first", d1, L + 6);
    chk("b2b_second", d2, 2 * (L + 6) + 1);
    chk("b2b_ready", rb, 0);
    chk("b2b_res", {result_hi, result_lo}, 64'h00000001_00000000);
    @(negedge clk);

    // Reset in the middle of an operation
    start = 1; op = 2'b11; src1 = 32'h89ABCDEF; src2 = 32'h13579BDF;
    @(posedge clk);
    dseen = 0;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      start = 0;
      if (done === 1'b1) dseen = 1;
      if (n == 3) reset = 1;
    end
    @(negedge clk);
    reset = 0;
    if (done === 1'b1) dseen = 1;
    chk("mid_rst_nodone", dseen, 0);
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_res", {result_hi, result_lo}, 64'h0);
    run_op(2'b01, 32'hDEADBEEF, 32'hCAFEF00D, 0);

    // Randomized operations with noise on the inputs while busy
    for (int i = 0; i < 25; i++) begin
      k = int'($urandom_range(0, 3));
      ra  = (k == 0) ? ($urandom & 32'h0000FFFF) : $urandom;
      rbv = (k == 1) ? ($urandom & 32'h0000FFFF) : $urandom;
      run_op(2'($urandom), ra, rbv, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
